adder_final_pipe: RTL and testbench



---
 rtl/adder_final_pipe_pkg.sv | 28 ++
 rtl/adder_final_pipe_if.sv | 30 +++
 rtl/adder_stage7.sv | 40 ++++
 rtl/gp_cell.sv | 14 +
 rtl/adder_final_pipe.sv | 89 ++++++++
 tb/tb_adder_final_pipe.sv | 253 +++++++++++++++++++++++++
 6 files changed

// File: rtl/adder_final_pipe_pkg.sv
// Shared widths, flag packing and helpers for the final adder section.
package adder_final_pipe_pkg;

    localparam int unsigned LEN_DATA = 63;
    localparam int unsigned DATA_W   = LEN_DATA + 1;
    localparam int unsigned PREFIX_W = DATA_W + 1;
    localparam int unsigned TAG_W    = 4;

    localparam int unsigned FLAG_COUT = 0;
    localparam int unsigned FLAG_OVF  = 1;
    localparam int unsigned FLAG_ZERO = 2;
    localparam int unsigned FLAG_NEG  = 3;
    localparam int unsigned FLAG_W    = 4;

    typedef logic [FLAG_W-1:0] flags_t;

    function automatic flags_t pack_flags(input logic cout, input logic ovf,
                                          input logic zero, input logic neg);
        flags_t f;
        f            = '0;
        f[FLAG_COUT] = cout;
        f[FLAG_OVF]  = ovf;
        f[FLAG_ZERO] = zero;
        f[FLAG_NEG]  = neg;
        return f;
    endfunction

endpackage

// File: rtl/adder_final_pipe_if.sv
// Upstream prefix-vector handshake plus downstream result handshake.
interface adder_final_pipe_if;
    import adder_final_pipe_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [PREFIX_W-1:0] g_in;
    logic [PREFIX_W-1:0] p_in;
    logic [DATA_W-1:0]   hs_in;
    logic [TAG_W-1:0]    tag_in;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   sum_out;
    logic                cout_out;
    logic                ovf_out;
    logic                zero_out;
    logic                neg_out;
    logic [TAG_W-1:0]    tag_out;

    modport slave (
        input  in_valid, g_in, p_in, hs_in, tag_in, out_ready,
        output in_ready, out_valid, sum_out, cout_out, ovf_out, zero_out, neg_out, tag_out
    );

    modport master (
        output in_valid, g_in, p_in, hs_in, tag_in, out_ready,
        input  in_ready, out_valid, sum_out, cout_out, ovf_out, zero_out, neg_out, tag_out
    );

endinterface

// File: rtl/adder_stage7.sv
// Span-32 combine and top-slot resolution; c_o[k] is the group generate over [k:0].
module adder_stage7 #(
    parameter int unsigned Width = 64
) (
    input  logic [Width:0] g_i,
    input  logic [Width:0] p_i,
    output logic [Width:0] c_o
);

    localparam int unsigned Half = Width / 2;

    logic [Width:Half] grp_p;
    logic              unused_p;

    assign c_o[Half-1:0] = g_i[Half-1:0];

    for (genvar k = Half; k < Width; k++) begin : g_span32
        gp_cell u_cell (
            .gl_i (g_i[k]),
            .pl_i (p_i[k]),
            .gr_i (g_i[Half-1]),
            .pr_i (p_i[Half-1]),
            .g_o  (c_o[k]),
            .p_o  (grp_p[k])
        );
    end

    // Top slot holds only its own bit term, so it needs the fully resolved [Width-1:0] group.
    gp_cell u_top (
        .gl_i (g_i[Width]),
        .pl_i (p_i[Width]),
        .gr_i (c_o[Width-1]),
        .pr_i (grp_p[Width-1]),
        .g_o  (c_o[Width]),
        .p_o  (grp_p[Width])
    );

    assign unused_p = ^{p_i[Half-2:0], grp_p[Width], grp_p[Width-2:Half]};

endmodule

// File: rtl/gp_cell.sv
// Prefix combine cell: left group (gl, pl) over right group (gr, pr).
module gp_cell (
    input  logic gl_i,
    input  logic pl_i,
    input  logic gr_i,
    input  logic pr_i,
    output logic g_o,
    output logic p_o
);

    assign g_o = gl_i | (pl_i & gr_i);
    assign p_o = pl_i & pr_i;

endmodule

// File: rtl/adder_final_pipe.sv
// Final 64-bit prefix-adder section: accept register, span-32 resolve, sum/flag output register.
module adder_final_pipe
    import adder_final_pipe_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    adder_final_pipe_if.slave bus
);

    logic                a_valid_q, a_valid_d;
    logic [PREFIX_W-1:0] g_q, p_q;
    logic [DATA_W-1:0]   hs_q;
    logic [TAG_W-1:0]    tag_a_q;

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    flags_t              flags_q, flags_d;
    logic [TAG_W-1:0]    tag_out_q;

    logic                advance, in_ready, accept, load_b;
    logic [PREFIX_W-1:0] carry;

    adder_stage7 #(
        .Width (DATA_W)
    ) u_stage7 (
        .g_i (g_q),
        .p_i (p_q),
        .c_o (carry)
    );

    // in_ready depends on out_ready and held state only, never on in_valid.
    always_comb begin
        advance     = !out_valid_q || bus.out_ready;
        in_ready    = !a_valid_q || advance;
        accept      = bus.in_valid && in_ready;
        load_b      = a_valid_q && advance;
        a_valid_d   = accept || (a_valid_q && !load_b);
        out_valid_d = advance ? a_valid_q : out_valid_q;
        sum_d       = hs_q ^ carry[DATA_W-1:0];
        flags_d     = pack_flags(carry[DATA_W], carry[DATA_W-1] ^ carry[DATA_W],
                                 ~|sum_d, sum_d[DATA_W-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            a_valid_q   <= a_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q     <= '0;
            p_q     <= '0;
            hs_q    <= '0;
            tag_a_q <= '0;
        end else if (accept) begin
            g_q     <= bus.g_in;
            p_q     <= bus.p_in;
            hs_q    <= bus.hs_in;
            tag_a_q <= bus.tag_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            flags_q   <= '0;
            tag_out_q <= '0;
        end else if (load_b) begin
            sum_q     <= sum_d;
            flags_q   <= flags_d;
            tag_out_q <= tag_a_q;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum_out   = sum_q;
    assign bus.cout_out  = flags_q[FLAG_COUT];
    assign bus.ovf_out   = flags_q[FLAG_OVF];
    assign bus.zero_out  = flags_q[FLAG_ZERO];
    assign bus.neg_out   = flags_q[FLAG_NEG];
    assign bus.tag_out   = tag_out_q;

endmodule

// File: tb/tb_adder_final_pipe.sv
// Directed table, stall/stream, mid-flight reset and random scoreboard checks for adder_final_pipe.
module tb_adder_final_pipe;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
        logic [3:0]  tag;
    } res_t;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        res_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    adder_final_pipe_if bus ();

    adder_final_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference for the upstream stages: serial group terms inside each 32-bit half.
    task automatic drive_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                            input logic [3:0] tag);
        logic [64:0] gs, ps, g, p;
        logic        gg, pp;
        int          base;
        gs[0] = cin;
        ps[0] = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            gs[k] = a[k-1] & b[k-1];
            ps[k] = a[k-1] ^ b[k-1];
        end
        for (int k = 0; k < 64; k++) begin
            base = (k / 32) * 32;
            gg   = gs[base];
            pp   = ps[base];
            for (int i = base + 1; i <= k; i++) begin
                gg = gs[i] | (ps[i] & gg);
                pp = ps[i] & pp;
            end
            g[k] = gg;
            p[k] = pp;
        end
        g[64] = gs[64];
        p[64] = ps[64];
        bus.g_in   = g;
        bus.p_in   = p;
        bus.hs_in  = a ^ b;
        bus.tag_in = tag;
    endtask

    function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic cin,
                                   input logic [3:0] tag);
        logic [64:0] full;
        res_t        r;
        full   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        r.sum  = full[63:0];
        r.cout = full[64];
        r.ovf  = (a[63] == b[63]) && (r.sum[63] != a[63]);
        r.zero = (r.sum == 64'd0);
        r.neg  = r.sum[63];
        r.tag  = tag;
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.sum  = bus.sum_out;
        r.cout = bus.cout_out;
        r.ovf  = bus.ovf_out;
        r.zero = bus.zero_out;
        r.neg  = bus.neg_out;
        r.tag  = bus.tag_out;
        return r;
    endfunction

    // mode 0: out_ready pattern 1,0,0 with in_valid held; mode 1: random valid/ready.
    task automatic run_stream(input int n, input bit rnd);
        res_t        expq[$];
        res_t        e;
        int          sent = 0, got = 0, inflight = 0, cyc = 0;
        logic [63:0] ca, cb;
        logic        ccin;
        logic [3:0]  ctag;
        logic        exp_rdy;
        bit          acc, dlv;
        ca = 64'h0123_4567_89AB_CDEF;
        cb = 64'h0000_0000_FFFF_FFF0;
        ccin = 1'b0;
        ctag = 4'd0;
        if (rnd) begin
            ca   = {$urandom, $urandom};
            cb   = {$urandom, $urandom};
            ccin = 1'($urandom_range(0, 1));
            ctag = 4'($urandom_range(0, 15));
        end
        while (got < n && cyc < n * 6 + 50) begin
            @(posedge clk);
            #1;
            bus.in_valid  = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : ((cyc % 3) == 0);
            drive_op(ca, cb, ccin, ctag);
            #1;
            exp_rdy = (inflight < 2) || bus.out_ready;
            check("stream_in_ready", 72'(bus.in_ready), 72'(exp_rdy));
            dlv = bus.out_valid && bus.out_ready;
            acc = bus.in_valid && bus.in_ready;
            if (dlv) begin
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stream_extra: got result tag %0h expected none", bus.tag_out);
                end else begin
                    e = expq.pop_front();
                    check("stream_result", dut_res(), e);
                end
                got++;
                inflight--;
            end
            if (acc) begin
                expq.push_back(model(ca, cb, ccin, ctag));
                sent++;
                inflight++;
                if (rnd) begin
                    ca   = {$urandom, $urandom};
                    cb   = {$urandom, $urandom};
                    ccin = 1'($urandom_range(0, 1));
                    ctag = 4'($urandom_range(0, 15));
                end else begin
                    ca   = 64'h0123_4567_89AB_CDEF * 64'(sent + 1);
                    cb   = {32'(sent), 32'hFFFF_FFF0};
                    ccin = 1'(sent % 2);
                    ctag = 4'(sent);
                end
            end
            cyc++;
        end
        check("stream_count", 72'(got), 72'(n));
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, '{64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0}};
        vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
                    '{64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1}};
        vecs[2] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0,
                    '{64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2}};
        vecs[3] = '{64'h0, 64'h0, 1'b1, '{64'h1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3}};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                    '{64'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd4}};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                    '{64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5}};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, '{64'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6}};
        vecs[7] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0,
                    '{64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7}};
        vecs[8] = '{64'h0, 64'h0, 1'b0, '{64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8}};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive_op(64'h0, 64'h0, 1'b0, 4'd0);

        #12;
        check("reset_out_valid", 72'(bus.out_valid), 72'd0);
        check("reset_outputs", dut_res(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", 72'(bus.in_ready), 72'd1);

        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            drive_op(vecs[i].a, vecs[i].b, vecs[i].cin, 4'(i));
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            check("vec_latency_1", 72'(bus.out_valid), 72'd0);
            @(posedge clk);
            #1;
            check("vec_latency_2", 72'(bus.out_valid), 72'd1);
            check("vec_result", dut_res(), vecs[i].exp);
        end

        run_stream(8, 1'b0);

        // Fill both stages under backpressure, then reset mid-cycle.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        drive_op(64'h5, 64'h3, 1'b0, 4'hA);
        @(posedge clk);
        #1;
        drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b0, 4'hB);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("full_in_ready", 72'(bus.in_ready), 72'd0);
        check("full_out_valid", 72'(bus.out_valid), 72'd1);
        check("full_head", dut_res(), model(64'h5, 64'h3, 1'b0, 4'hA));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 72'(bus.out_valid), 72'd0);
        check("midrst_outputs", dut_res(), '0);
        check("midrst_in_ready", 72'(bus.in_ready), 72'd1);
        #10;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_stale", 72'(bus.out_valid), 72'd0);
        end
        check("post_rst_in_ready", 72'(bus.in_ready), 72'd1);

        run_stream(10000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
